alu_reservation_station: RTL and testbench
==========================================

// Module: alu_reservation_station
// PURPOSE
//  Receiving end of the decoder->ALU dispatch interface. It buffers dispatched ALU ops
//  until both source operands are valid, snoops the common data bus (CDB) for missing
//  tags, and issues one ready op per cycle to the integer ALU. It sits between Decoder
//  and the ALU, alongside the ROB, in the Tomasulo core.
// PARAMETERS
//  ENTRIES   4   number of station slots (power of 2, >=2)
//  DATA_W    32  operand/result width (`dataWidth)
//  TAG_W     4   ROB tag width (`tagWidth); `tagFree means "operand valid"
//  OP_W      6   internal opcode width (`newopWidth)
// PORTS
//  clk          in   1       core clock; all state updates on posedge
//  rst          in   1       asynchronous reset, active-low
//  in_enable    in   1       dispatch strobe from Decoder (aluEnable)
//  in_data      in   3*TAG_W+2*DATA_W+OP_W  {dest,tag2,data2,tag1,data1,op}, MSB first (aluData)
//  full         out  1       all slots busy; Decoder/IF must stall dispatch
//  cdb_valid    in   1       CDB broadcast valid
//  cdb_tag      in   TAG_W   tag of broadcast result
//  cdb_data     in   DATA_W  broadcast result value
//  flush        in   1       mispredict/ROB clear; kill all slots and pending issue
//  issue_valid  out  1       registered; op presented to ALU this cycle
//  issue_op     out  OP_W    opcode of issued op
//  issue_a      out  DATA_W  operand 1 value
//  issue_b      out  DATA_W  operand 2 value (imm already in data2 slot for RI class)
//  issue_dest   out  TAG_W   ROB tag the ALU broadcasts its result under
// BEHAVIOUR
//  Reset (rst=0, async): all busy bits 0, full=0, issue_valid=0, issue_op/a/b=0,
//   issue_dest=`tagFree. Slot payload registers need not be reset.
//  Per slot: busy, op, dest, tag1,data1, tag2,data2. Ready = busy & tag1==`tagFree & tag2==`tagFree.
//  Dispatch: on posedge with in_enable=1 and full=0, write in_data into lowest-index free
//   slot and set busy. Decoder drives in_data on negedge, so it is stable at posedge.
//   in_enable while full=1: ignored; no slot is modified.
//  CDB snoop: on posedge with cdb_valid=1, every busy slot with tagX==cdb_tag (X=1,2)
//   loads dataX<=cdb_data and sets tagX<=`tagFree. Both operands may match the same broadcast.
//  Dispatch/CDB bypass: if the op being dispatched carries tagX==cdb_tag in the same cycle,
//   it is stored with dataX=cdb_data, tagX=`tagFree (the broadcast is not lost).
//  cdb_tag==`tagFree with cdb_valid=1 matches nothing (operands already valid are untouched).
//  Issue select: combinational lowest-index ready slot among registered state. On posedge,
//   if a ready slot exists: issue_* <= slot fields, issue_valid<=1, that slot's busy<=0;
//   else issue_valid<=0. One issue per cycle. There is no ALU back-pressure: ALU accepts every cycle.
//  Latency: dispatch of a fully-ready op at edge N -> issue_valid at edge N+1 (visible
//   N+1..N+2). An operand woken by CDB at edge N -> earliest issue at edge N+1.
//  Freed slot (issued at edge N) is reusable by dispatch at edge N+1; dispatch at N does not
//   target it because selection uses pre-edge busy bits.
//  full = &busy (registered state, combinational out). It does not anticipate the same-cycle
//   issue, so it is conservative by one cycle.
//  flush: on posedge with flush=1, all busy<=0, issue_valid<=0; same-cycle dispatch, CDB and
//   issue are discarded. flush overrides everything except rst.
//  Reset mid-operation: all state returns to reset values immediately, regardless of clk.
// STRUCTURE
//  Shared package/defines: `tagFree, `dataWidth, `tagWidth, `newopWidth, in_data field
//   offsets (ALU_DEST_RANGE, ALU_TAG2_RANGE, ...) so Decoder packing and this unpacking stay tied.
//  Sub-module rs_priority_enc (ENTRIES-wide lowest-set-bit encoder + any flag), used twice:
//   free-slot select and ready-slot select.
// TESTING
//  1 Reset: rst=0 mid-cycle -> issue_valid=0, full=0 asynchronously. Release, idle -> no issue.
//  2 Ready op: dispatch ADD tag1=tag2=`tagFree, data1=5, data2=7, dest=3 -> next edge
//    issue_valid=1, op=ADD, a=5, b=7, dest=3; following edge issue_valid=0.
//  3 Wakeup: dispatch SUB with tag1=2 and data2=9 free; cdb(2,100) two cycles later -> issue one
//    edge after the broadcast with a=100, b=9. Same test with cdb(2,..) in the dispatch cycle
//    (bypass) -> issue on the next edge.
//  4 Fill/full: 4 dispatches waiting on tag 6 -> full=1; 5th dispatch ignored; cdb(6,1) wakes all;
//    issue order is slots 0,1,2,3 on consecutive edges; full drops after the first issue edge.
//  5 Dual match: tag1=tag2=4, cdb(4,0xDEAD) -> a=b=0xDEAD. cdb_valid=0 with tag 4 -> no wakeup.
//  6 Flush: 3 slots busy and one issuing; flush=1 with concurrent in_enable -> issue_valid=0,
//    full=0, no later issue until new dispatch.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared ALU dispatch definitions: widths, the free-tag encoding and the packed
// dispatch word layout, so the Decoder's packing and this station's unpacking stay tied.
// Field order is {dest, tag2, data2, tag1, data1, op}, MSB first.
package alu_reservation_station_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 6;

    // Tag value meaning "operand already holds its value"
    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    // Dispatch word width and field LSB/MSB offsets
    localparam int IN_W      = 3*TAG_W + 2*DATA_W + OP_W;
    localparam int OP_LSB    = 0;
    localparam int OP_MSB    = OP_LSB + OP_W - 1;
    localparam int DATA1_LSB = OP_MSB + 1;
    localparam int DATA1_MSB = DATA1_LSB + DATA_W - 1;
    localparam int TAG1_LSB  = DATA1_MSB + 1;
    localparam int TAG1_MSB  = TAG1_LSB + TAG_W - 1;
    localparam int DATA2_LSB = TAG1_MSB + 1;
    localparam int DATA2_MSB = DATA2_LSB + DATA_W - 1;
    localparam int TAG2_LSB  = DATA2_MSB + 1;
    localparam int TAG2_MSB  = TAG2_LSB + TAG_W - 1;
    localparam int DEST_LSB  = TAG2_MSB + 1;
    localparam int DEST_MSB  = DEST_LSB + TAG_W - 1;

    // One station slot payload; also the dispatch word layout (first field is MSB)
    typedef struct packed {
        logic [TAG_W-1:0]  dest;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] data2;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] data1;
        logic [OP_W-1:0]   op;
    } alu_dispatch_t;

    // A CDB broadcast captures an operand waiting on its tag; the free tag never matches
    function automatic logic cdb_hit(input logic cdb_vld,
                                     input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] tag);
        return cdb_vld && (cdb_tag != TAG_FREE) && (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Decoder/CDB-facing bundle of the ALU reservation station plus its issue port.
// master = the driving environment (Decoder, CDB, flush source, ALU observer).
// slave  = the reservation station itself.
interface alu_reservation_station_if
    import alu_reservation_station_pkg::*;
    ();

    logic              in_enable;
    logic [IN_W-1:0]   in_data;
    logic              full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              flush;
    logic              issue_valid;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [TAG_W-1:0]  issue_dest;

    modport master (
        output in_enable, in_data, cdb_valid, cdb_tag, cdb_data, flush,
        input  full, issue_valid, issue_op, issue_a, issue_b, issue_dest
    );

    modport slave (
        input  in_enable, in_data, cdb_valid, cdb_tag, cdb_data, flush,
        output full, issue_valid, issue_op, issue_a, issue_b, issue_dest
    );

endinterface

// File: rtl/alu_reservation_station_rs_priority_enc.sv
// Lowest-set-bit encoder (rs_priority_enc): index of the lowest requesting bit plus an any flag.
// Latency: purely combinational.
// Backpressure: none; idx is 0 when no bit is set, qualify with any.
module alu_reservation_station_rs_priority_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top so the lowest set bit is the last (winning) assignment
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/alu_reservation_station.sv
// Buffers dispatched ALU ops until both operands are valid, snoops the CDB, issues one per cycle.
// Latency: ready op dispatched at edge N issues at edge N+1; CDB wakeup at N issues at N+1 earliest.
// Backpressure: full (=&busy, one cycle conservative) stalls dispatch; ALU accepts every cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_reservation_station_if.slave  rs
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy;
    alu_dispatch_t      slots [ENTRIES];

    logic [ENTRIES-1:0] ready;
    logic [IDX_W-1:0]   free_idx;
    logic               free_any;
    logic [IDX_W-1:0]   rdy_idx;
    logic               rdy_any;
    logic               disp_fire;
    alu_dispatch_t      din;
    alu_dispatch_t      din_byp;

    assign din       = alu_dispatch_t'(rs.in_data);
    assign disp_fire = rs.in_enable && free_any;
    assign rs.full   = &busy;

    // A slot is ready once it is occupied and neither operand waits on a tag
    always_comb begin
        ready = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = busy[i] && (slots[i].tag1 == TAG_FREE) && (slots[i].tag2 == TAG_FREE);
        end
    end

    // Capture a same-cycle broadcast into the op being dispatched so it is not lost
    always_comb begin
        din_byp = din;
        if (cdb_hit(rs.cdb_valid, rs.cdb_tag, din.tag1)) begin
            din_byp.data1 = rs.cdb_data;
            din_byp.tag1  = TAG_FREE;
        end
        if (cdb_hit(rs.cdb_valid, rs.cdb_tag, din.tag2)) begin
            din_byp.data2 = rs.cdb_data;
            din_byp.tag2  = TAG_FREE;
        end
    end

    alu_reservation_station_rs_priority_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_free_sel (
        .req (~busy),
        .idx (free_idx),
        .any (free_any)
    );

    alu_reservation_station_rs_priority_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_ready_sel (
        .req (ready),
        .idx (rdy_idx),
        .any (rdy_any)
    );

    // Occupancy: issue frees the selected slot, dispatch claims the lowest free one, flush kills all
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else if (rs.flush) begin
            busy <= '0;
        end else begin
            if (rdy_any) begin
                busy[rdy_idx] <= 1'b0;
            end
            if (disp_fire) begin
                busy[free_idx] <= 1'b1;
            end
        end
    end

    // Slot payload: load on dispatch, otherwise pick up matching CDB results (no reset needed)
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (disp_fire && (free_idx == IDX_W'(i))) begin
                slots[i] <= din_byp;
            end else if (busy[i]) begin
                if (cdb_hit(rs.cdb_valid, rs.cdb_tag, slots[i].tag1)) begin
                    slots[i].data1 <= rs.cdb_data;
                    slots[i].tag1  <= TAG_FREE;
                end
                if (cdb_hit(rs.cdb_valid, rs.cdb_tag, slots[i].tag2)) begin
                    slots[i].data2 <= rs.cdb_data;
                    slots[i].tag2  <= TAG_FREE;
                end
            end
        end
    end

    // Registered issue port: present the lowest ready slot to the ALU each cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs.issue_valid <= 1'b0;
            rs.issue_op    <= '0;
            rs.issue_a     <= '0;
            rs.issue_b     <= '0;
            rs.issue_dest  <= TAG_FREE;
        end else if (rs.flush) begin
            rs.issue_valid <= 1'b0;
        end else if (rdy_any) begin
            rs.issue_valid <= 1'b1;
            rs.issue_op    <= slots[rdy_idx].op;
            rs.issue_a     <= slots[rdy_idx].data1;
            rs.issue_b     <= slots[rdy_idx].data2;
            rs.issue_dest  <= slots[rdy_idx].dest;
        end else begin
            rs.issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for the ALU reservation station: reset, ready issue, CDB wakeup/bypass,
// fill/full ordering, dual operand match, flush and asynchronous reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_alu_reservation_station;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_reservation_station_if rs_bus ();

    alu_reservation_station #(.ENTRIES(4)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_valid(input string tag, input logic exp);
        chk({tag, ".valid"}, 32'(rs_bus.issue_valid), 32'(exp));
    endtask

    task automatic chk_full(input string tag, input logic exp);
        chk({tag, ".full"}, 32'(rs_bus.full), 32'(exp));
    endtask

    task automatic chk_issue(input string tag, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] dest);
        chk_valid(tag, 1'b1);
        chk({tag, ".op"},   32'(rs_bus.issue_op),   32'(op));
        chk({tag, ".a"},    rs_bus.issue_a,         a);
        chk({tag, ".b"},    rs_bus.issue_b,         b);
        chk({tag, ".dest"}, 32'(rs_bus.issue_dest), 32'(dest));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one dispatch word {dest,tag2,data2,tag1,data1,op} across one rising edge
    task automatic disp(input logic [5:0] op, input logic [31:0] d1, input logic [3:0] t1,
                        input logic [31:0] d2, input logic [3:0] t2, input logic [3:0] dest);
        rs_bus.in_enable = 1'b1;
        rs_bus.in_data   = {dest, t2, d2, t1, d1, op};
        step();
        rs_bus.in_enable = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        rs_bus.cdb_valid = 1'b1;
        rs_bus.cdb_tag   = tag;
        rs_bus.cdb_data  = data;
        step();
        rs_bus.cdb_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        rs_bus.in_enable = 1'b0;
        rs_bus.in_data   = '0;
        rs_bus.cdb_valid = 1'b0;
        rs_bus.cdb_tag   = '0;
        rs_bus.cdb_data  = '0;
        rs_bus.flush     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_valid("reset", 1'b0);
        chk_full("reset", 1'b0);
        chk("reset.dest", 32'(rs_bus.issue_dest), 32'd0);
        chk("reset.a", rs_bus.issue_a, 32'd0);
        rst = 1'b1;
        step();
        step();
        chk_valid("idle", 1'b0);
        chk_full("idle", 1'b0);

        // Fully ready op: issues one edge after dispatch, for exactly one cycle
        disp(OP_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3);
        chk_valid("ready.disp_edge", 1'b0);
        step();
        chk_issue("ready", OP_ADD, 32'd5, 32'd7, 4'd3);
        step();
        chk_valid("ready.after", 1'b0);
        chk_full("ready.after", 1'b0);

        // Wakeup: operand 1 waits on tag 2, broadcast two cycles after dispatch
        disp(OP_SUB, 32'd0, 4'd2, 32'd9, 4'd0, 4'd5);
        chk_valid("wake.wait0", 1'b0);
        step();
        chk_valid("wake.wait1", 1'b0);
        cdb(4'd2, 32'd100);
        chk_valid("wake.cdb_edge", 1'b0);
        step();
        chk_issue("wake", OP_SUB, 32'd100, 32'd9, 4'd5);
        step();
        chk_valid("wake.after", 1'b0);

        // Bypass: broadcast in the dispatch cycle is captured by the incoming op
        rs_bus.cdb_valid = 1'b1;
        rs_bus.cdb_tag   = 4'd2;
        rs_bus.cdb_data  = 32'd55;
        disp(OP_SUB, 32'd0, 4'd2, 32'd9, 4'd0, 4'd7);
        rs_bus.cdb_valid = 1'b0;
        step();
        chk_issue("bypass", OP_SUB, 32'd55, 32'd9, 4'd7);
        step();
        chk_valid("bypass.after", 1'b0);

        // Fill: four ops wait on tag 6, a fifth (ready) dispatch is ignored while full
        for (int i = 0; i < 4; i++) begin
            disp(OP_ADD, 32'd0, 4'd6, 32'(10 + i), 4'd0, 4'(8 + i));
        end
        chk_full("fill", 1'b1);
        chk_valid("fill", 1'b0);
        disp(OP_ADD, 32'd99, 4'd0, 32'd99, 4'd0, 4'd15);
        chk_full("fill.5th", 1'b1);
        chk_valid("fill.5th", 1'b0);
        cdb(4'd6, 32'd1);
        chk_valid("fill.cdb_edge", 1'b0);
        chk_full("fill.cdb_edge", 1'b1);
        step();
        chk_issue("fill.s0", OP_ADD, 32'd1, 32'd10, 4'd8);
        chk_full("fill.s0", 1'b0);
        step();
        chk_issue("fill.s1", OP_ADD, 32'd1, 32'd11, 4'd9);
        step();
        chk_issue("fill.s2", OP_ADD, 32'd1, 32'd12, 4'd10);
        step();
        chk_issue("fill.s3", OP_ADD, 32'd1, 32'd13, 4'd11);
        step();
        chk_valid("fill.drained", 1'b0);
        chk_full("fill.drained", 1'b0);

        // Dual match: both operands wait on tag 4; an invalid broadcast must not wake them
        disp(OP_ADD, 32'd0, 4'd4, 32'd0, 4'd4, 4'd2);
        rs_bus.cdb_tag  = 4'd4;
        rs_bus.cdb_data = 32'd1234;
        step();
        step();
        chk_valid("dual.novalid", 1'b0);
        cdb(4'd4, 32'hDEAD);
        step();
        chk_issue("dual", OP_ADD, 32'hDEAD, 32'hDEAD, 4'd2);
        step();
        chk_valid("dual.after", 1'b0);

        // Free-tag broadcast matches nothing: valid operands of a bypassed dispatch are kept
        rs_bus.cdb_valid = 1'b1;
        rs_bus.cdb_tag   = 4'd0;
        rs_bus.cdb_data  = 32'd777;
        disp(OP_ADD, 32'd33, 4'd0, 32'd44, 4'd0, 4'd1);
        rs_bus.cdb_valid = 1'b0;
        step();
        chk_issue("freetag", OP_ADD, 32'd33, 32'd44, 4'd1);
        step();

        // Flush: three waiting slots plus one about to issue, flush with concurrent dispatch
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 32'd0, 4'd9, 32'(i), 4'd0, 4'(1 + i));
        end
        disp(OP_ADD, 32'd20, 4'd0, 32'd21, 4'd0, 4'd4);
        chk_full("flush.pre", 1'b1);
        rs_bus.flush     = 1'b1;
        rs_bus.in_enable = 1'b1;
        rs_bus.in_data   = {4'd6, 4'd0, 32'd2, 4'd0, 32'd1, OP_ADD};
        step();
        rs_bus.flush     = 1'b0;
        rs_bus.in_enable = 1'b0;
        chk_valid("flush", 1'b0);
        chk_full("flush", 1'b0);
        cdb(4'd9, 32'd5);
        chk_valid("flush.cdb", 1'b0);
        step();
        chk_valid("flush.later1", 1'b0);
        step();
        chk_valid("flush.later2", 1'b0);
        disp(OP_ADD, 32'd1, 4'd0, 32'd2, 4'd0, 4'd12);
        step();
        chk_issue("flush.new", OP_ADD, 32'd1, 32'd2, 4'd12);
        step();

        // Asynchronous reset while full
        for (int i = 0; i < 4; i++) begin
            disp(OP_ADD, 32'd0, 4'd7, 32'd0, 4'd0, 4'(i + 1));
        end
        chk_full("arst.pre", 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_full("arst", 1'b0);
        chk_valid("arst", 1'b0);
        #1 rst = 1'b1;
        step();
        cdb(4'd7, 32'd3);
        step();
        chk_valid("arst.killed", 1'b0);

        // Asynchronous reset while an issue is being presented
        disp(OP_ADD, 32'd3, 4'd0, 32'd4, 4'd0, 4'd13);
        step();
        chk_issue("arst2.pre", OP_ADD, 32'd3, 32'd4, 4'd13);
        #2 rst = 1'b0;
        #1;
        chk_valid("arst2", 1'b0);
        chk("arst2.dest", 32'(rs_bus.issue_dest), 32'd0);
        chk("arst2.op", 32'(rs_bus.issue_op), 32'd0);
        chk("arst2.a", rs_bus.issue_a, 32'd0);
        chk("arst2.b", rs_bus.issue_b, 32'd0);
        #1 rst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
